// File: rtl/hosted_mem_arbiter_pkg.sv
// Shared widths and payload field offsets for the hosted memory arbiter.
package hosted_mem_arbiter_pkg;

    // Control fields under the address: len(8) + size(3) + burst(2).
    localparam int A_CTRL_W   = 13;
    localparam int W_LAST_BIT = 0;
    localparam int R_ID_LSB   = 3;
    localparam int B_ID_LSB   = 2;

    function automatic int ix_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int a_width(input int id_w, input int addr_w);
        return id_w + addr_w + A_CTRL_W;
    endfunction

    function automatic int w_width(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

endpackage

// File: rtl/hs_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus index; the pointer moves past
// the winner only when the grant is actually taken.
module hs_rr_arbiter #(
    parameter int N    = 3,
    parameter int IX_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            accept,
    output logic [N-1:0]    grant,
    output logic [IX_W-1:0] grant_idx,
    output logic            any
);

    logic [IX_W-1:0] ptr;
    logic [IX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            cand = IX_W'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && any) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hosted_mem_arbiter.sv
// Shares one AXI burst master port among N requesters: round-robin AR/AW,
// W ordered by AW grant, R/B routed back by the index held in the ID MSBs.
module hosted_mem_arbiter
    import hosted_mem_arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WQ_DEPTH = 4,
    localparam int IX_W    = ix_width(N),
    localparam int MID_W   = ID_W + IX_W,
    localparam int A_W     = a_width(ID_W, ADDR_W),
    localparam int W_W     = w_width(DATA_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              s_arvalid,
    output logic [N-1:0]              s_arready,
    input  logic [N*A_W-1:0]          s_ar,
    input  logic [N-1:0]              s_awvalid,
    output logic [N-1:0]              s_awready,
    input  logic [N*A_W-1:0]          s_aw,
    input  logic [N-1:0]              s_wvalid,
    output logic [N-1:0]              s_wready,
    input  logic [N*W_W-1:0]          s_w,
    output logic [N-1:0]              s_rvalid,
    input  logic [N-1:0]              s_rready,
    output logic [DATA_W+ID_W+2:0]    s_r,
    output logic [N-1:0]              s_bvalid,
    input  logic [N-1:0]              s_bready,
    output logic [ID_W+1:0]           s_b,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [A_W+IX_W-1:0]       m_ar,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [A_W+IX_W-1:0]       m_aw,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [W_W-1:0]            m_w,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [DATA_W+MID_W+2:0]   m_r,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [MID_W+1:0]          m_b,
    output logic                      err_bad_id
);

    // Handshakes: a beat moves on a cycle where valid && ready; valid never
    // waits on ready, and a held master-side payload stays stable until taken.

    localparam int WQ_PW = $clog2(WQ_DEPTH);

    logic [N-1:0]    ar_grant, aw_grant;
    logic [IX_W-1:0] ar_idx, aw_idx;
    logic            ar_any, aw_any, ar_load, aw_load;

    logic [IX_W-1:0]  wq_mem [WQ_DEPTH];
    logic [WQ_PW:0]   wq_wr, wq_rd;
    logic [IX_W-1:0]  wq_head;
    logic             wq_empty, wq_full, wq_push, wq_pop;

    assign ar_load = !m_arvalid || m_arready;
    assign aw_load = (!m_awvalid || m_awready) && !wq_full;

    hs_rr_arbiter #(.N(N), .IX_W(IX_W)) u_ar_arb (
        .clk(clk), .rst_n(rst_n), .req(s_arvalid), .accept(ar_load),
        .grant(ar_grant), .grant_idx(ar_idx), .any(ar_any)
    );

    hs_rr_arbiter #(.N(N), .IX_W(IX_W)) u_aw_arb (
        .clk(clk), .rst_n(rst_n), .req(s_awvalid), .accept(aw_load),
        .grant(aw_grant), .grant_idx(aw_idx), .any(aw_any)
    );

    assign s_arready = (rst_n && ar_load) ? ar_grant : '0;
    assign s_awready = (rst_n && aw_load) ? aw_grant : '0;

    // The ID is the payload MSB field, so prepending the index widens it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arvalid <= 1'b0;
            m_ar      <= '0;
            m_awvalid <= 1'b0;
            m_aw      <= '0;
        end else begin
            if (ar_load) begin
                m_arvalid <= ar_any;
                if (ar_any) m_ar <= {ar_idx, s_ar[int'(ar_idx)*A_W +: A_W]};
            end
            if (aw_load) begin
                m_awvalid <= aw_any;
                if (aw_any) m_aw <= {aw_idx, s_aw[int'(aw_idx)*A_W +: A_W]};
            end
        end
    end

    assign wq_empty = (wq_wr == wq_rd);
    assign wq_full  = (wq_wr[WQ_PW] != wq_rd[WQ_PW]) &&
                      (wq_wr[WQ_PW-1:0] == wq_rd[WQ_PW-1:0]);
    assign wq_head  = wq_mem[wq_rd[WQ_PW-1:0]];
    assign wq_push  = aw_load && aw_any;

    always_comb begin
        m_wvalid = 1'b0;
        m_w      = '0;
        s_wready = '0;
        if (!wq_empty) begin
            m_wvalid          = s_wvalid[wq_head];
            m_w               = s_w[int'(wq_head)*W_W +: W_W];
            s_wready[wq_head] = m_wready;
        end
    end

    assign wq_pop = m_wvalid && m_wready && m_w[W_LAST_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq_wr <= '0;
            wq_rd <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) wq_mem[i] <= '0;
        end else begin
            if (wq_push) begin
                wq_mem[wq_wr[WQ_PW-1:0]] <= aw_idx;
                wq_wr <= wq_wr + 1'b1;
            end
            if (wq_pop) wq_rd <= wq_rd + 1'b1;
        end
    end

    logic [IX_W-1:0] r_ix, b_ix;
    logic            r_bad, b_bad;

    assign r_ix  = m_r[R_ID_LSB+ID_W +: IX_W];
    assign b_ix  = m_b[B_ID_LSB+ID_W +: IX_W];
    assign r_bad = int'(r_ix) >= N;
    assign b_bad = int'(b_ix) >= N;

    // Responses with an index outside the requester range are sunk.
    always_comb begin
        s_rvalid = '0;
        s_bvalid = '0;
        m_rready = 1'b0;
        m_bready = 1'b0;
        if (rst_n) begin
            if (r_bad) begin
                m_rready = 1'b1;
            end else begin
                s_rvalid[r_ix] = m_rvalid;
                m_rready       = s_rready[r_ix];
            end
            if (b_bad) begin
                m_bready = 1'b1;
            end else begin
                s_bvalid[b_ix] = m_bvalid;
                m_bready       = s_bready[b_ix];
            end
        end
    end

    assign s_r = {m_r[DATA_W+MID_W+2 -: DATA_W], m_r[R_ID_LSB +: ID_W], m_r[R_ID_LSB-1:0]};
    assign s_b = m_b[B_ID_LSB+ID_W-1:0];
    assign err_bad_id = rst_n && ((m_rvalid && r_bad) || (m_bvalid && b_bad));

endmodule
